// File: rtl/muldiv_if.sv
// Issue/result bundle between the datapath and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic            i_flush;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  // Datapath side: issues operations, consumes results.
  modport master (
    output i_start, i_flush, i_funct3, i_rs1, i_rs2,
    input  o_busy, o_done, o_result
  );

  // Unit side.
  modport slave (
    input  i_start, i_flush, i_funct3, i_rs1, i_rs2,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one shared shift/add-subtract engine,
// fixed XLEN+1 cycle latency for every operation.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic     i_clk,
  input  logic     i_reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  // {hi (XLEN+1), lo (XLEN)}: product accumulator or remainder:quotient
  logic [2*XLEN:0]   acc_q, acc_d;
  logic              neg_q, neg_d, div0_q, div0_d, ovf_q, ovf_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   res_q, res_d;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  // Operand decode at issue time.
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]        a_abs, b_abs;

  // Signedness of each operand and its magnitude for the unsigned engine.
  always_comb begin
    rs1_s = bus.i_rs1;
    rs2_s = bus.i_rs2;
    sgn_a = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010) ||
            (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b110);
    sgn_b = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b100) ||
            (bus.i_funct3 == 3'b110);
    a_neg = sgn_a && (rs1_s < 0);
    b_neg = sgn_b && (rs2_s < 0);
    a_abs = cond_neg(bus.i_rs1, a_neg);
    b_abs = cond_neg(bus.i_rs2, b_neg);
  end

  // One engine iteration: shift-add for multiply, restoring shift-subtract for divide.
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN:0] div_sh;
  logic [XLEN+1:0] div_trial;
  logic [2*XLEN:0] step;

  // Next accumulator value for the current operation class.
  always_comb begin
    mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, a_q} : '0);
    div_sh    = {acc_q[2*XLEN-1:0], 1'b0};
    div_trial = {1'b0, div_sh[2*XLEN:XLEN]} - {2'b00, b_q};
    if (f3_q[2]) begin
      step = div_trial[XLEN+1] ? div_sh
                               : {div_trial[XLEN:0], div_sh[XLEN-1:1], 1'b1};
    end else begin
      step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign-corrected result selection used on the FIX edge.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  // Pick product half / quotient / remainder and apply special cases.
  always_comb begin
    prod_s = cond_neg2(acc_q[2*XLEN-1:0], neg_q);
    quo_s  = cond_neg(acc_q[XLEN-1:0], neg_q);
    rem_s  = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
    case (f3_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div0_q)     fix_res = '1;
        else if (ovf_q) fix_res = {1'b1, {(XLEN-1){1'b0}}};
        else            fix_res = quo_s;
      end
      default:        fix_res = ovf_q ? '0 : rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.i_start) state_d = CALC;
        CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_d  = cnt_q;
    f3_d   = f3_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    div0_d = div0_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    res_d  = res_q;
    if (bus.i_flush) begin
      busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            f3_d   = bus.i_funct3;
            a_d    = a_abs;
            b_d    = b_abs;
            acc_d  = {{(XLEN+1){1'b0}}, (bus.i_funct3[2] ? a_abs : b_abs)};
            // remainder follows the dividend; everything else follows sign xor
            neg_d  = (bus.i_funct3[2] && bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
            div0_d = bus.i_funct3[2] && (bus.i_rs2 == '0);
            ovf_d  = bus.i_funct3[2] && sgn_a &&
                     (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2 == '1);
            cnt_d  = CNT_W'(XLEN);
            busy_d = 1'b1;
          end
        end
        CALC: begin
          acc_d = step;
          cnt_d = cnt_q - CNT_W'(1);
        end
        FIX: begin
          res_d  = fix_res;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      f3_q   <= f3_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      div0_q <= div0_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_result = res_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operation set for the processor datapath, parametrised in operand width. The datapath issues an operation with operands and funct3, stalls on `o_busy`, and writes `o_result` back through the result mux on `o_done`. A single shared shift/add-subtract engine serves both multiply and divide, so every operation takes a fixed XLEN+1 cycles.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `CNT_W`, default $clog2(XLEN)+1: width of the iteration counter; derived, do not override.

Ports:
- `i_clk`  input  1  clock; all state changes on the rising edge.
- `i_reset`  input  1  asynchronous, active-low reset.
- `i_start`  input  1  issue request; sampled only when `o_busy`=0.
- `i_flush`  input  1  abort any in-flight operation (pipeline redirect).
- `i_funct3`  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_rs1`  input  XLEN  operand A (multiplicand / dividend).
- `i_rs2`  input  XLEN  operand B (multiplier / divisor).
- `o_busy`  output  1  operation in progress; the datapath stalls the PC while it is high.
- `o_done`  output  1  single-cycle pulse; `o_result` is valid.
- `o_result`  output  XLEN  result; holds its value until the next `o_done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `i_start`=1, `i_flush`=0 → CALC. On this edge:
  - latch `i_funct3`;
  - latch the operand magnitudes (absolute value for signed operands: A for MULH/MULHSU/DIV/REM, B for MULH/DIV/REM);
  - latch the result-negation flag and the special-case flags;
  - load counter = XLEN.
- CALC performs one iteration per cycle and decrements the counter. Move to FIX when counter reaches 1 on an edge, i.e. exactly XLEN CALC cycles.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder in XLEN+1-bit arithmetic.
- FIX → IDLE. On this edge `o_result` is loaded with the selected, sign-corrected value and `o_done` is set for one cycle.
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Product negated if exactly one signed operand is negative. Quotient negated if the dividend and divisor signs differ. Remainder takes the dividend's sign.
- Special cases are resolved in FIX and keep the same latency:
  - divisor = 0: DIV/DIVU → all ones; REM/REMU → original `i_rs1`.
  - signed overflow (A = −2^(XLEN−1), B = −1): DIV → −2^(XLEN−1); REM → 0.
- `i_start` while `o_busy`=1 is ignored; the operands are not relatched.
- `i_flush`=1 in any state → IDLE on the next edge. `o_done` is not asserted and `o_result` is not updated. Flush has priority over `i_start` in the same cycle.
- Reset (`i_reset`=0, asynchronous, at any time including mid-operation): state IDLE, `o_busy`=0, `o_done`=0, `o_result`=0, counter and internal registers cleared.

## Timing
- `i_start` sampled at edge E0.
  - `o_busy`=1 from E0 through edge E0+XLEN+1.
  - `o_busy`=0 and `o_done`=1 after edge E0+XLEN+1, for exactly one cycle.
  - Total latency: XLEN+1 cycles.
- `o_busy` is registered and is high in every CALC and FIX cycle.
- Back-to-back: `i_start` may be asserted in the `o_done` cycle and is accepted on that edge, giving no bubble between operations.
- `o_done` deasserts on the following edge; `o_result` remains stable.
- Outputs are registered only; there is no combinational path from any input to any output.

## Test plan
- Reset mid-CALC: start MUL, assert `i_reset`=0 at cycle 5 → `o_busy`, `o_done` and `o_result` all 0 immediately (asynchronously). After release, the unit is idle and accepts a new start.
- MUL/MULH, XLEN=32: A=0xFFFF_FFFF (−1), B=0x0000_0002.
  - MUL → 0xFFFF_FFFE, MULH → 0xFFFF_FFFF, MULHU → 0x0000_0001, MULHSU → 0xFFFF_FFFF.
  - Each with `o_done` exactly 33 cycles after the start edge.
- DIV/REM signs: A=−7 (0xFFFF_FFF9), B=2 → DIV=0xFFFF_FFFD (−3), REM=0xFFFF_FFFF (−1), DIVU=0x7FFF_FFFC, REMU=1.
- Special cases:
  - B=0, A=0x1234_5678 → DIV=DIVU=0xFFFF_FFFF, REM=REMU=0x1234_5678.
  - A=0x8000_0000, B=0xFFFF_FFFF → DIV=0x8000_0000, REM=0.
  - All with 33-cycle latency.
- Handshake:
  - Pulse `i_start` with new operands during busy → ignored; the original result is returned.
  - Start in the `o_done` cycle → second `o_done` exactly 33 cycles later.
- Flush: start DIVU, assert `i_flush` at cycle 10 → `o_busy`=0 next cycle, no `o_done`, `o_result` unchanged from its previous value.
- XLEN=8 instance: MULHU 0xFF×0xFF → 0xFE; DIVU 200/7 → 28 (0x1C), REMU → 4; latency 9 cycles.
